// File: rtl/param_lifo.sv
// param_lifo -- parametrised synchronous LIFO (stack).
//
// Purpose:
//   Last-in-first-out buffer between a producer and a consumer in one clock
//   domain. It has a registered pop output with a one-cycle valid strobe.
//   A push and a pop in the same cycle are defined behaviour:
//     - replace-top when the stack holds data;
//     - bypass when the stack is empty.
//   It also provides an occupancy count, an almost-full threshold and
//   one-cycle overflow/underflow pulses.
//
// Parameters:
//   DATA_W    data word width in bits (>= 1)
//   DEPTH     number of entries (>= 2, any value, not only powers of two)
//   AFULL_TH  almost_full asserts when count >= AFULL_TH (1..DEPTH)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wr_en        push request
//   rd_en        pop request
//   data_in      push data
//   data_out     registered popped word, holds between pops
//   rd_valid     one-cycle pulse, data_out updated this cycle
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AFULL_TH
//   count        current occupancy, 0..DEPTH
//   overflow     one-cycle pulse, push rejected because the stack was full
//   underflow    one-cycle pulse, pop rejected because the stack was empty

module param_lifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  // The address only needs to reach DEPTH-1.
  // The count must reach DEPTH, so it is one state wider.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage array. It is deliberately not reset so that it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     top_addr;
  logic              rd_mem;
  logic              bypass;

  logic              empty_w, full_w;

  // Flags come only from the count register, so they never glitch
  // relative to count.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // The top of the stack is mem[count-1].
  // The address is meaningless when empty, but it is only used when not empty.
  assign top_addr = AW'(count_q - CW'(1));

  always_comb begin
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = top_addr;
    rd_mem      = 1'b0;
    bypass      = 1'b0;

    case ({wr_en, rd_en})
      2'b10: begin
        if (full_w) begin
          overflow_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = AW'(count_q);
          count_d   = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty_w) begin
          underflow_d = 1'b1;
        end else begin
          rd_mem     = 1'b1;
          rd_valid_d = 1'b1;
          count_d    = count_q - CW'(1);
        end
      end
      2'b11: begin
        rd_valid_d = 1'b1;
        if (empty_w) begin
          // Nothing is stored: hand the pushed word straight to the consumer.
          bypass = 1'b1;
        end else begin
          // Replace-top.
          // The read returns the old top because the write to the same
          // address lands on the same edge (read-before-write).
          rd_mem    = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = top_addr;
        end
      end
      default: ;
    endcase
  end

  // Reset gates the write so that a push during reset leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (rd_mem) begin
        data_out_q <= mem[top_addr];
      end else if (bypass) begin
        data_out_q <= data_in;
      end
    end
  end

  assign data_out    = data_out_q;
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign empty       = empty_w;
  assign full        = full_w;
  assign almost_full = (count_q >= CW'(AFULL_TH));
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
